// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled 8N1 framing with start-glitch rejection.
// Consumes the baud generator's one-cycle clk_enable tick; flags bad stop bits.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_enable,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state, state_next;
  logic [TW-1:0]        tick_cnt, tick_next;
  logic [BW-1:0]        bit_cnt, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_next;
  logic                 valid_next, ferr_next;
  logic                 rx_meta, rx_s;

  // Synchronizer resets to the idle (high) line level so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep the two flops as a true two-stage pipeline.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      tick_cnt    <= tick_next;
      bit_cnt     <= bit_next;
      shift_reg   <= shift_next;
      rx_data     <= data_next;
      rx_valid    <= valid_next;
      frame_error <= ferr_next;
      busy        <= (state_next != IDLE);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_reg;
    data_next  = rx_data;
    valid_next = 1'b0;
    ferr_next  = 1'b0;

    if (clk_enable) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_next = START;
            tick_next  = '0;
          end
        end

        START: begin
          if (tick_cnt != HALF_LAST) begin
            tick_next = tick_cnt + TW'(1);
          end else if (!rx_s) begin
            state_next = DATA;
            tick_next  = '0;
            bit_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end

        DATA: begin
          if (tick_cnt != FULL_LAST) begin
            tick_next = tick_cnt + TW'(1);
          end else begin
            shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
            tick_next  = '0;
            if (bit_cnt == BIT_LAST) state_next = STOP;
            else                     bit_next   = bit_cnt + BW'(1);
          end
        end

        STOP: begin
          // Leaving at mid stop bit gives half a bit of slack to catch a back-to-back start.
          if (tick_cnt != FULL_LAST) begin
            tick_next = tick_cnt + TW'(1);
          end else begin
            if (rx_s) begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end else begin
              ferr_next = 1'b1;
            end
            tick_next  = '0;
            state_next = IDLE;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

endmodule
